// File: rtl/if_fetch_ctrl.sv
// Non-overlapped instruction-fetch sequencer: one read per instruction, stale responses dropped on redirect.
// Define IF_FETCH_PERF_EN to implement the fetch_cnt/flush_cnt performance counters.
module if_fetch_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              redirect,
    input  logic              id_stall,
    output logic              ar_valid,
    output logic [ADDR_W-1:0] ar_addr,
    input  logic              ar_ready,
    input  logic              r_valid,
    input  logic [DATA_W-1:0] r_data,
    input  logic [1:0]        r_resp,
    output logic              r_ready,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst_out,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              pc_write,
    output logic              bus_err,
    output logic [31:0]       fetch_cnt,
    output logic [31:0]       flush_cnt
);

    typedef enum logic [1:0] {LOAD, ADDR, WAIT, HOLD} state_e;

    localparam logic [DATA_W-1:0] NOP = DATA_W'(32'h0000_0013);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   req_pc_q, req_pc_d;
    logic                drop_q, drop_d;
    logic                inst_valid_q, inst_valid_d;
    logic [DATA_W-1:0]   inst_out_q, inst_out_d;
    logic [ADDR_W-1:0]   inst_pc_q, inst_pc_d;
    logic                bus_err_q, bus_err_d;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d      = state_q;
        req_pc_d     = req_pc_q;
        drop_d       = drop_q;
        inst_valid_d = inst_valid_q;
        inst_out_d   = inst_out_q;
        inst_pc_d    = inst_pc_q;
        bus_err_d    = 1'b0;
        pc_write     = 1'b0;

        unique case (state_q)
            LOAD: begin
                if (redirect) begin
                    pc_write = 1'b1;
                end else begin
                    req_pc_d = pc_in;
                    state_d  = ADDR;
                end
            end
            ADDR: begin
                // The address stays up after a redirect; the response is discarded later.
                if (redirect) begin
                    pc_write = 1'b1;
                    drop_d   = 1'b1;
                end
                if (ar_ready) state_d = WAIT;
            end
            WAIT: begin
                if (r_valid) begin
                    if (drop_q || redirect) begin
                        pc_write = redirect;
                        drop_d   = 1'b0;
                        state_d  = LOAD;
                    end else begin
                        inst_valid_d = 1'b1;
                        inst_pc_d    = req_pc_q;
                        inst_out_d   = (r_resp != 2'b00) ? NOP : r_data;
                        bus_err_d    = (r_resp != 2'b00);
                        state_d      = HOLD;
                    end
                end else if (redirect) begin
                    pc_write = 1'b1;
                    drop_d   = 1'b1;
                end
            end
            HOLD: begin
                if (redirect || !id_stall) begin
                    pc_write     = 1'b1;
                    inst_valid_d = 1'b0;
                    state_d      = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst) begin
            state_q      <= LOAD;
            req_pc_q     <= '0;
            drop_q       <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_out_q   <= '0;
            inst_pc_q    <= '0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_pc_q     <= req_pc_d;
            drop_q       <= drop_d;
            inst_valid_q <= inst_valid_d;
            inst_out_q   <= inst_out_d;
            inst_pc_q    <= inst_pc_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign ar_valid   = (state_q == ADDR);
    assign ar_addr    = req_pc_q;
    assign r_ready    = (state_q == WAIT);
    assign inst_valid = inst_valid_q;
    assign inst_out   = inst_out_q;
    assign inst_pc    = inst_pc_q;
    assign bus_err    = bus_err_q;

`ifdef IF_FETCH_PERF_EN
    logic        fetch_inc, flush_inc;
    logic [31:0] fetch_cnt_q, flush_cnt_q;

    assign fetch_inc = (state_q == HOLD) && !redirect && !id_stall;
    assign flush_inc = (state_q == WAIT) && r_valid && (drop_q || redirect);

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_q + 32'(fetch_inc);
            flush_cnt_q <= flush_cnt_q + 32'(flush_inc);
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign fetch_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Self-checking bench for if_fetch_ctrl: directed and randomized fetch episodes against a
// timeline model of each fetch, with a behavioural PC register closing the pc_write loop.
module tb_if_fetch_ctrl;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
`ifdef IF_FETCH_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef enum int {K_NORM, K_RD_LOAD, K_RD_ADDR, K_RD_WAIT_SAME, K_RD_WAIT_BEFORE, K_RD_HOLD} kind_e;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] pc_in;
    logic              redirect, id_stall, ar_ready, r_valid;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_resp;
    logic              ar_valid, r_ready, inst_valid, pc_write, bus_err;
    logic [ADDR_W-1:0] ar_addr, inst_pc;
    logic [DATA_W-1:0] inst_out;
    logic [31:0]       fetch_cnt, flush_cnt;

    int          total = 0;
    int          bad = 0;
    int          exp_fetch = 0;
    int          exp_flush = 0;
    logic [31:0] tgt_v = '0;

    always #5 clk = ~clk;

    if_fetch_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .redirect(redirect), .id_stall(id_stall),
        .ar_valid(ar_valid), .ar_addr(ar_addr), .ar_ready(ar_ready),
        .r_valid(r_valid), .r_data(r_data), .r_resp(r_resp), .r_ready(r_ready),
        .inst_valid(inst_valid), .inst_out(inst_out), .inst_pc(inst_pc),
        .pc_write(pc_write), .bus_err(bus_err), .fetch_cnt(fetch_cnt), .flush_cnt(flush_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic st, input logic arr, input logic rv,
                         input logic [31:0] rdat, input logic [1:0] rs);
        redirect = rd;
        id_stall = st;
        ar_ready = arr;
        r_valid  = rv;
        r_data   = rdat;
        r_resp   = rs;
    endtask

    // Check one cycle's control outputs, then clock it; the PC register loads on pc_write.
    task automatic cyc(input string tag, input logic e_arv, input logic e_rr, input logic e_iv,
                       input logic e_pw, input logic e_be);
        logic pw;
        #1;
        check({tag, ".ar_valid"}, 32'(ar_valid), 32'(e_arv));
        check({tag, ".r_ready"}, 32'(r_ready), 32'(e_rr));
        check({tag, ".inst_valid"}, 32'(inst_valid), 32'(e_iv));
        check({tag, ".pc_write"}, 32'(pc_write), 32'(e_pw));
        check({tag, ".bus_err"}, 32'(bus_err), 32'(e_be));
        pw = pc_write;
        @(posedge clk);
        #1;
        if (pw) pc_in = redirect ? tgt_v : pc_in + 32'd4;
    endtask

    task automatic chk_cnt(input string tag);
        check({tag, ".fetch_cnt"}, fetch_cnt, PERF ? 32'(exp_fetch) : 32'd0);
        check({tag, ".flush_cnt"}, flush_cnt, PERF ? 32'(exp_flush) : 32'd0);
    endtask

    task automatic chk_reset(input string tag);
        check({tag, ".ar_valid"}, 32'(ar_valid), 32'd0);
        check({tag, ".r_ready"}, 32'(r_ready), 32'd0);
        check({tag, ".inst_valid"}, 32'(inst_valid), 32'd0);
        check({tag, ".inst_out"}, inst_out, 32'd0);
        check({tag, ".inst_pc"}, inst_pc, 32'd0);
        check({tag, ".pc_write"}, 32'(pc_write), 32'd0);
        check({tag, ".bus_err"}, 32'(bus_err), 32'd0);
        check({tag, ".fetch_cnt"}, fetch_cnt, 32'd0);
        check({tag, ".flush_cnt"}, flush_cnt, 32'd0);
    endtask

    // One fetch from LOAD through discard or consume. aw/rw are ready/valid wait cycles,
    // st the HOLD stall cycles, and tgt the redirect target when the kind has one.
    task automatic episode(input kind_e k, input int aw, input int rw, input int st,
                           input logic [1:0] rs, input logic [31:0] word, input logic [31:0] tgt);
        logic [31:0] a;
        logic        rd;
        logic [31:0] exp_inst;
        tgt_v = tgt;
        chk_cnt("load");
        if (k == K_RD_LOAD) begin
            drive(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, '0, 2'b00);
            cyc("load_rd", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        a = pc_in;
        drive(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, '0, 2'b00);
        cyc("load", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i <= aw; i++) begin
            rd = (k == K_RD_ADDR) && (i == 0);
            drive(rd, 1'($urandom_range(0, 1)), i == aw, 1'b0, '0, 2'b00);
            check("addr.ar_addr", ar_addr, a);
            cyc("addr", 1'b1, 1'b0, 1'b0, rd, 1'b0);
        end
        for (int i = 0; i <= rw; i++) begin
            rd = ((k == K_RD_WAIT_SAME) && (i == rw)) || ((k == K_RD_WAIT_BEFORE) && (i == 0));
            drive(rd, 1'($urandom_range(0, 1)), 1'b0, i == rw, word, (i == rw) ? rs : 2'b00);
            cyc("wait", 1'b0, 1'b1, 1'b0, rd, 1'b0);
        end
        if (k inside {K_RD_ADDR, K_RD_WAIT_SAME, K_RD_WAIT_BEFORE}) begin
            exp_flush++;
        end else begin
            exp_inst = (rs != 2'b00) ? 32'h0000_0013 : word;
            for (int i = 0; i <= st; i++) begin
                rd = (k == K_RD_HOLD) && (i == st);
                drive(rd, (i < st) || rd, 1'b0, 1'b0, '0, 2'b00);
                check("hold.inst_out", inst_out, exp_inst);
                check("hold.inst_pc", inst_pc, a);
                cyc("hold", 1'b0, 1'b0, 1'b1, i == st, (i == 0) && (rs != 2'b00));
            end
            if (k != K_RD_HOLD) exp_fetch++;
        end
    endtask

    initial begin
        kind_e       k;
        int          rw;
        logic [1:0]  rs;

        rst   = 1'b0;
        pc_in = 32'h0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 2'b00);
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");
        rst = 1'b1;

        // Zero-wait fetches from 0, then a 5-cycle ID stall.
        episode(K_NORM, 0, 0, 0, 2'b00, 32'h00A0_0093, 32'h0);
        episode(K_NORM, 0, 0, 0, 2'b00, 32'h00A0_0093, 32'h0);
        episode(K_NORM, 1, 2, 5, 2'b00, $urandom, 32'h0);

        // Redirect in ADDR with ar_ready held low two cycles; next read at 0x100.
        episode(K_RD_ADDR, 2, 1, 0, 2'b00, $urandom, 32'h0000_0100);
        check("after_rd_addr.pc", pc_in, 32'h0000_0100);
        episode(K_NORM, 0, 0, 0, 2'b00, $urandom, 32'h0);

        episode(K_RD_WAIT_SAME, 0, 0, 0, 2'b00, $urandom, 32'h0000_0300);
        episode(K_NORM, 0, 1, 0, 2'b00, $urandom, 32'h0);
        episode(K_NORM, 0, 0, 1, 2'b10, $urandom, 32'h0);
        episode(K_RD_WAIT_BEFORE, 1, 2, 0, 2'b00, $urandom, 32'h0000_0400);
        episode(K_RD_HOLD, 0, 0, 2, 2'b00, $urandom, 32'h0000_0500);
        episode(K_RD_LOAD, 0, 0, 0, 2'b00, $urandom, 32'h0000_0600);

        for (int n = 0; n < 60; n++) begin
            k  = kind_e'($urandom_range(0, 5));
            rw = $urandom_range(0, 3);
            if (k == K_RD_WAIT_BEFORE && rw == 0) rw = 1;
            rs = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            episode(k, $urandom_range(0, 3), rw, $urandom_range(0, 3), rs, $urandom,
                    $urandom & 32'hFFFF_FFFC);
        end

        // Reset asserted while waiting for a response.
        chk_cnt("pre_rst");
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 2'b00);
        cyc("rst_load", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, '0, 2'b00);
        cyc("rst_addr", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 2'b00);
        cyc("rst_wait", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_reset("rst_mid");
        exp_fetch = 0;
        exp_flush = 0;
        rst   = 1'b1;
        pc_in = 32'h0000_0200;
        episode(K_NORM, 0, 0, 0, 2'b00, $urandom, 32'h0);
        episode(K_NORM, 1, 0, 0, 2'b00, $urandom, 32'h0);
        chk_cnt("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
